// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: reset/NOP constants, fetch FSM encodings,
// opcode constants common to the fetch and branch units, and target alignment.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // JALR-style LSB clear, applied to every redirect target.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return target & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: trap > taken branch > pc+4, with target alignment and
// detection of taken branches whose aligned target is not word aligned.
module pc_next_sel
  import rv32_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_addr,
  output logic [31:0] pc_plus_4,
  output logic [31:0] next_pc,
  output logic [31:0] redirect_addr,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] br_eff;
  logic [31:0] trap_eff;
  logic        br_ok;

  always_comb begin
    br_eff        = align_target(branch_target);
    trap_eff      = align_target(trap_addr);
    pc_plus_4     = pc + 32'd4;
    // A misaligned branch does not redirect; a trap overrides it entirely.
    br_ok         = branch_taken && !br_eff[1];
    misaligned    = branch_taken && !trap_taken && br_eff[1];
    redirect      = trap_taken || br_ok;
    redirect_addr = trap_taken ? trap_eff : br_eff;
    next_pc       = redirect ? redirect_addr : pc_plus_4;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch stage: owns the PC, drives instruction memory, registers
// the returned instruction and kills the wrong-path slot on every redirect.
module pc_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ready_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_addr_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] imem_addr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        misaligned_instr_out
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] pend_p0, pend_nxt;
  logic [31:0] instr_p1, instr_nxt;
  logic        vld_p1, vld_nxt;
  logic        mis_p1, mis_nxt;

  logic [31:0] sel_pc_plus_4;
  logic [31:0] sel_next_pc;
  logic [31:0] sel_redirect_addr;
  logic        sel_redirect;
  logic        sel_misaligned;
  logic [31:0] trap_eff;
  logic [31:0] hold_target;

  pc_next_sel u_pc_next_sel (
    .pc            (pc_p0),
    .branch_taken  (branch_taken_in),
    .branch_target (branch_target_in),
    .trap_taken    (trap_taken_in),
    .trap_addr     (trap_addr_in),
    .pc_plus_4     (sel_pc_plus_4),
    .next_pc       (sel_next_pc),
    .redirect_addr (sel_redirect_addr),
    .redirect      (sel_redirect),
    .misaligned    (sel_misaligned)
  );

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_p0;
    pend_nxt    = pend_p0;
    instr_nxt   = instr_p1;
    vld_nxt     = vld_p1;
    mis_nxt     = 1'b0;
    trap_eff    = align_target(trap_addr_in);
    // A trap arriving while held replaces the parked redirect; branches are wrong-path.
    hold_target = trap_taken_in ? trap_eff : pend_p0;

    unique case (state)
      FS_BOOT, FS_RUN: begin
        if (ready_in) begin
          pc_nxt    = sel_next_pc;
          instr_nxt = sel_redirect ? NOP_INSTR : imem_rdata_in;
          vld_nxt   = !sel_redirect;
          mis_nxt   = sel_misaligned;
          state_nxt = FS_RUN;
        end else if (sel_redirect) begin
          pend_nxt  = sel_redirect_addr;
          state_nxt = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (ready_in) begin
          pc_nxt    = hold_target;
          instr_nxt = NOP_INSTR;
          vld_nxt   = 1'b0;
          state_nxt = FS_RUN;
        end else begin
          pend_nxt  = hold_target;
        end
      end
      default: state_nxt = FS_BOOT;
    endcase
  end

  // Stage boundary: PC / pending redirect (p0) and decode-side instruction (p1).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= FS_BOOT;
      pc_p0    <= RESET_PC;
      pend_p0  <= RESET_PC;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_p0    <= pc_nxt;
      pend_p0  <= pend_nxt;
      instr_p1 <= instr_nxt;
      vld_p1   <= vld_nxt;
      mis_p1   <= mis_nxt;
    end
  end

  assign pc_out               = pc_p0;
  assign imem_addr_out        = pc_p0;
  assign pc_plus_4_out        = sel_pc_plus_4;
  assign instr_out            = instr_p1;
  assign instr_valid_out      = vld_p1;
  assign misaligned_instr_out = mis_p1;

endmodule
